lfsr_galois_gen: RTL and testbench

Parametrised Galois LFSR pseudo-random generator, the successor to the fixed 16-bit generator used by the game logic. It adds configurable width, polynomial, reset seed, and multi-step advance per enable. It also supports a runtime seed load with all-zero lock-up protection, and a period-wrap flag. It sits beside the game state machine, supplying obstacle/segment randomness, and one instance per random channel is allowed.

---
 rtl/lfsr_galois_gen.sv | 97 +++++++++
 tb/tb_lfsr_galois_gen.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_galois_gen.sv
// lfsr_galois_gen
// Parametrised Galois LFSR pseudo-random generator. Each enabled cycle the
// state advances by STEPS single shifts. A runtime seed can be loaded, with
// an all-zero seed replaced by the SEED parameter. A period-wrap pulse fires
// when the state returns to the value it started from.
//
// Parameters:
//   WIDTH  state width in bits (2..32)
//   TAPS   Galois tap mask, WIDTH bits, bit 0 set
//   SEED   reset / substitute state, nonzero
//   STEPS  single shifts applied per enabled cycle (1..WIDTH)
//
// Ports:
//   Clk      in   clock, rising edge
//   Rst      in   synchronous active-low reset
//   Enable   in   advance the state by STEPS shifts
//   Load     in   load Seed into the state (wins over Enable)
//   Seed     in   runtime seed, WIDTH bits
//   Q        out  current state (registered)
//   Bit      out  serial output, Q[WIDTH-1]
//   Wrap     out  one-cycle pulse: state returned to the start value
//   ZeroFix  out  one-cycle pulse: a zero seed was replaced by SEED
module lfsr_galois_gen #(
    parameter int                 WIDTH = 16,
    parameter logic [WIDTH-1:0]   TAPS  = 16'h002D,
    parameter logic [WIDTH-1:0]   SEED  = '1,
    parameter int                 STEPS = 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Enable,
    input  logic             Load,
    input  logic [WIDTH-1:0] Seed,
    output logic [WIDTH-1:0] Q,
    output logic             Bit,
    output logic             Wrap,
    output logic             ZeroFix
);

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] start;
    logic [WIDTH-1:0] stepped;
    logic             wrap_r;
    logic             zero_fix_r;

    // One Galois shift: shift towards the MSB, and when the bit falling out
    // of the top is set, fold it back in through the tap mask.
    function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] s);
        logic fb;
        fb = s[WIDTH-1];
        return {s[WIDTH-2:0], 1'b0} ^ (TAPS & {WIDTH{fb}});
    endfunction

    // STEPS shifts chained combinationally so a multi-step advance still
    // produces a new value every enabled cycle.
    always_comb begin
        stepped = state;
        for (int i = 0; i < STEPS; i++) begin
            stepped = shift1(stepped);
        end
    end

    // Reset beats Load beats Enable. The state cannot reach zero from a
    // nonzero value, so only the load path needs a zero check.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state      <= SEED;
            start      <= SEED;
            wrap_r     <= 1'b0;
            zero_fix_r <= 1'b0;
        end else if (Load) begin
            wrap_r <= 1'b0;
            if (Seed != '0) begin
                state      <= Seed;
                start      <= Seed;
                zero_fix_r <= 1'b0;
            end else begin
                state      <= SEED;
                start      <= SEED;
                zero_fix_r <= 1'b1;
            end
        end else if (Enable) begin
            state      <= stepped;
            wrap_r     <= (stepped == start);
            zero_fix_r <= 1'b0;
        end else begin
            wrap_r     <= 1'b0;
            zero_fix_r <= 1'b0;
        end
    end

    assign Q       = state;
    assign Bit     = state[WIDTH-1];
    assign Wrap    = wrap_r;
    assign ZeroFix = zero_fix_r;

endmodule

// File: tb/tb_lfsr_galois_gen.sv
// tb_lfsr_galois_gen
// Self-checking bench for lfsr_galois_gen. Three instances run side by side:
// defaults, STEPS=2, and a 4-bit generator. A polynomial-arithmetic model
// (multiply by x modulo the feedback polynomial) predicts every output each
// cycle; literal values from hand calculation pin the model.
module tb_lfsr_galois_gen;

    typedef struct {
        logic [63:0] q;
        logic [63:0] start;
        logic        wrap;
        logic        zf;
    } mstate_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // instance 0: defaults
    logic        rst0 = 1'b0, en0 = 1'b0, ld0 = 1'b0;
    logic [15:0] seed0 = '0;
    logic [15:0] q0;
    logic        bit0, wrap0, zf0;
    // instance 1: STEPS=2
    logic        rst1 = 1'b0, en1 = 1'b0, ld1 = 1'b0;
    logic [15:0] seed1 = '0;
    logic [15:0] q1;
    logic        bit1, wrap1, zf1;
    // instance 2: 4-bit, x^4+x+1, seed 1
    logic        rst2 = 1'b0, en2 = 1'b0, ld2 = 1'b0;
    logic [3:0]  seed2 = '0;
    logic [3:0]  q2;
    logic        bit2, wrap2, zf2;

    lfsr_galois_gen dut0 (
        .Clk(clk), .Rst(rst0), .Enable(en0), .Load(ld0), .Seed(seed0),
        .Q(q0), .Bit(bit0), .Wrap(wrap0), .ZeroFix(zf0)
    );

    lfsr_galois_gen #(.STEPS(2)) dut1 (
        .Clk(clk), .Rst(rst1), .Enable(en1), .Load(ld1), .Seed(seed1),
        .Q(q1), .Bit(bit1), .Wrap(wrap1), .ZeroFix(zf1)
    );

    lfsr_galois_gen #(.WIDTH(4), .TAPS(4'h3), .SEED(4'h1), .STEPS(1)) dut2 (
        .Clk(clk), .Rst(rst2), .Enable(en2), .Load(ld2), .Seed(seed2),
        .Q(q2), .Bit(bit2), .Wrap(wrap2), .ZeroFix(zf2)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Multiply by x modulo p(x) = x^w + taps(x), n times.
    function automatic logic [63:0] mul_x(input logic [63:0] s, input int w,
                                          input logic [63:0] taps, input int n);
        logic [63:0] poly;
        logic [63:0] v;
        poly = (64'd1 << w) | taps;
        v = s;
        for (int k = 0; k < n; k++) begin
            v = v << 1;
            if (v[w]) v = v ^ poly;
        end
        return v;
    endfunction

    function automatic mstate_t upd(input mstate_t m, input logic r, input logic l,
                                    input logic e, input logic [63:0] sd, input int w,
                                    input logic [63:0] taps, input logic [63:0] seedp,
                                    input int steps);
        mstate_t n;
        n = m;
        if (!r) begin
            n.q = seedp; n.start = seedp; n.wrap = 1'b0; n.zf = 1'b0;
        end else if (l) begin
            n.wrap = 1'b0;
            if (sd != 0) begin
                n.q = sd; n.start = sd; n.zf = 1'b0;
            end else begin
                n.q = seedp; n.start = seedp; n.zf = 1'b1;
            end
        end else if (e) begin
            n.q = mul_x(m.q, w, taps, steps);
            n.wrap = (n.q == m.start);
            n.zf = 1'b0;
        end else begin
            n.wrap = 1'b0; n.zf = 1'b0;
        end
        return n;
    endfunction

    mstate_t m0, m1, m2;
    bit v0 = 0, v1 = 0, v2 = 0;

    always @(posedge clk) begin
        m0 = upd(m0, rst0, ld0, en0, {48'd0, seed0}, 16, 64'h2D, 64'hFFFF, 1);
        m1 = upd(m1, rst1, ld1, en1, {48'd0, seed1}, 16, 64'h2D, 64'hFFFF, 2);
        m2 = upd(m2, rst2, ld2, en2, {60'd0, seed2}, 4, 64'h3, 64'h1, 1);
        if (!rst0) v0 = 1;
        if (!rst1) v1 = 1;
        if (!rst2) v2 = 1;
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (v0) begin
            check("dut0 Q", {48'd0, q0}, m0.q);
            check("dut0 Bit", {63'd0, bit0}, {63'd0, m0.q[15]});
            check("dut0 Wrap", {63'd0, wrap0}, {63'd0, m0.wrap});
            check("dut0 ZeroFix", {63'd0, zf0}, {63'd0, m0.zf});
        end
        if (v1) begin
            check("dut1 Q", {48'd0, q1}, m1.q);
            check("dut1 Bit", {63'd0, bit1}, {63'd0, m1.q[15]});
            check("dut1 Wrap", {63'd0, wrap1}, {63'd0, m1.wrap});
            check("dut1 ZeroFix", {63'd0, zf1}, {63'd0, m1.zf});
        end
        if (v2) begin
            check("dut2 Q", {60'd0, q2}, m2.q);
            check("dut2 Bit", {63'd0, bit2}, {63'd0, m2.q[3]});
            check("dut2 Wrap", {63'd0, wrap2}, {63'd0, m2.wrap});
            check("dut2 ZeroFix", {63'd0, zf2}, {63'd0, m2.zf});
        end
    end

    task automatic drive0(input logic r, input logic l, input logic e, input logic [15:0] s);
        rst0 = r; ld0 = l; en0 = e; seed0 = s;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive1(input logic r, input logic l, input logic e, input logic [15:0] s);
        rst1 = r; ld1 = l; en1 = e; seed1 = s;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive2(input logic r, input logic l, input logic e, input logic [3:0] s);
        rst2 = r; ld2 = l; en2 = e; seed2 = s;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic thread0();
        int wcount;
        int wfirst;
        drive0(1'b0, 1'b0, 1'b0, 16'h0);
        drive0(1'b0, 1'b0, 1'b0, 16'h0);
        check("reset Q", {48'd0, q0}, 64'hFFFF);
        check("reset Bit", {63'd0, bit0}, 64'd1);
        check("reset Wrap", {63'd0, wrap0}, 64'd0);
        check("reset ZeroFix", {63'd0, zf0}, 64'd0);
        drive0(1'b1, 1'b0, 1'b1, 16'h0);
        check("first step", {48'd0, q0}, 64'hFFD3);
        drive0(1'b1, 1'b0, 1'b1, 16'h0);
        check("second step", {48'd0, q0}, 64'hFF8B);

        // full period from reset
        drive0(1'b0, 1'b0, 1'b0, 16'h0);
        wcount = 0;
        wfirst = 0;
        for (int i = 1; i <= 65535; i++) begin
            drive0(1'b1, 1'b0, 1'b1, 16'h0);
            if (wrap0 === 1'b1) begin
                wcount++;
                if (wfirst == 0) wfirst = i;
            end
        end
        check("wrap count", wcount, 64'd1);
        check("wrap index", wfirst, 64'd65535);
        check("wrap Q", {48'd0, q0}, 64'hFFFF);
        drive0(1'b1, 1'b0, 1'b0, 16'h0);
        check("wrap released", {63'd0, wrap0}, 64'd0);

        // load 1 and walk up to the top bit
        drive0(1'b1, 1'b1, 1'b0, 16'h0001);
        check("load 1", {48'd0, q0}, 64'h0001);
        for (int i = 0; i < 15; i++) drive0(1'b1, 1'b0, 1'b1, 16'h0);
        check("15 steps from 1", {48'd0, q0}, 64'h8000);
        drive0(1'b1, 1'b0, 1'b1, 16'h0);
        check("fold through taps", {48'd0, q0}, 64'h002D);
        drive0(1'b1, 1'b1, 1'b0, 16'h0000);
        check("zero seed Q", {48'd0, q0}, 64'hFFFF);
        check("zero seed ZeroFix", {63'd0, zf0}, 64'd1);
        drive0(1'b1, 1'b0, 1'b0, 16'h0);
        check("ZeroFix pulse ends", {63'd0, zf0}, 64'd0);

        // priority
        drive0(1'b1, 1'b1, 1'b1, 16'h1234);
        check("load over enable", {48'd0, q0}, 64'h1234);
        drive0(1'b0, 1'b1, 1'b1, 16'h4321);
        check("reset over load", {48'd0, q0}, 64'hFFFF);

        for (int i = 0; i < 1500; i++) begin
            drive0(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) == 0),
                   ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom));
        end
    endtask

    task automatic thread1();
        drive1(1'b0, 1'b0, 1'b0, 16'h0);
        drive1(1'b1, 1'b0, 1'b1, 16'h0);
        check("steps2 first", {48'd0, q1}, 64'hFF8B);
        for (int i = 0; i < 1500; i++) begin
            drive1(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) == 0),
                   ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom));
        end
    endtask

    task automatic thread2();
        logic [3:0] seq [15];
        logic [3:0] exp_q;
        seq = '{4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB, 4'h5,
                4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9, 4'h1};
        drive2(1'b0, 1'b0, 1'b0, 4'h0);
        check("w4 reset", {60'd0, q2}, 64'h1);
        for (int k = 0; k < 45; k++) begin
            drive2(1'b1, 1'b0, 1'b1, 4'h0);
            exp_q = seq[k % 15];
            check("w4 seq", {60'd0, q2}, {60'd0, exp_q});
            check("w4 wrap", {63'd0, wrap2}, {63'd0, (exp_q == 4'h1)});
        end
        for (int i = 0; i < 800; i++) begin
            drive2(($urandom_range(0, 49) != 0), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom));
        end
    endtask

    initial begin
        fork
            thread0();
            thread1();
            thread2();
        join
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #(10 * 90000);
        errors++;
        $display("FAIL timeout: got no completion expected completion within 90000 cycles");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
